circular_deque: RTL and testbench
=================================

# circular_deque

Parametrised circular double-ended buffer: successor to the single-ended circular buffer, with push and pop at either end, an occupancy count, programmable almost-full/almost-empty thresholds, registered read data with a valid strobe, and sticky-free overflow/underflow pulses. It sits between a producer and a consumer that need either FIFO or LIFO order, chosen per operation. Capacity need not be a power of two.

## Interface
- `word_size`, 32: data width in bits.
- `capacity`, 64: number of storage entries, ≥ 2, any integer.
- `af_level`, capacity-2: `almost_full` asserts when count ≥ af_level.
- `ae_level`, 2: `almost_empty` asserts when count ≤ ae_level.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `wr` in 1: push request.
- `wr_front` in 1: push end select, 0 = back (tail), 1 = front (head); sampled with `wr`.
- `rd` in 1: pop request.
- `rd_back` in 1: pop end select, 0 = front (head), 1 = back (tail); sampled with `rd`.
- `data_in` in word_size: push data.
- `data_out` out word_size: registered pop data.
- `valid_out` out 1: one-cycle strobe, `data_out` holds a newly popped word.
- `count` out clog2(capacity+1): current occupancy.
- `full`, `empty` out 1: count == capacity / count == 0.
- `almost_full`, `almost_empty` out 1: threshold flags.
- `overflow`, `underflow` out 1: one-cycle pulse on a rejected push / pop.

## Operation
- State: `head` (index of front element), `tail` (index one past back element), `count`; indices in 0..capacity-1, increment from capacity-1 wraps to 0, decrement from 0 wraps to capacity-1 (explicit compare, no power-of-two masking).
- Front pop: read mem[head], head+1. Back pop: tail-1, read mem[new tail].
- Back push: write mem[tail], tail+1. Front push: head-1, write mem[new head].
- Ordering within a cycle: the pop is evaluated first on the pre-cycle state; the push is then applied to the post-pop pointers.
- Pop accepted iff `rd` and count > 0; otherwise `underflow` pulses, no state change from the pop.
- Push accepted iff `wr` and (count < capacity or a pop is accepted the same cycle); otherwise `overflow` pulses, memory and pointers untouched.
- Simultaneous push+pop on empty: pop rejected (`underflow`), push accepted, count → 1; no bypass of `data_in` to `data_out`.
- Simultaneous push+pop on full: both accepted, count unchanged.
- Same-end push+pop (e.g. front/front): popped value is the old entry, the new word occupies the same slot; count unchanged.
- count: +1 on accepted push only, −1 on accepted pop only, unchanged for both or neither.
- `full`, `empty`, `almost_*`, `count` are derived from the registered count, so they reflect state after the last edge.
- Memory contents are not cleared by reset.

## Timing
- Reset (`rst` high at an edge): head = tail = 0, count = 0, `data_out` = 0, `valid_out` = 0, `overflow` = `underflow` = 0; `empty` = 1, `full` = 0, `almost_empty` = 1, `almost_full` = 0 (for af_level > 0). Reset overrides any `wr`/`rd` in the same cycle, including mid-operation.
- Pop latency 1: an accepted pop at edge N gives `data_out` valid and `valid_out` = 1 after edge N; `valid_out` drops the next cycle unless another pop is accepted. `data_out` holds its last value otherwise.
- Push visible in `count` / flags after the same edge; a pushed word is poppable the next cycle.
- `overflow` / `underflow` assert for exactly the cycle after the offending edge.
- Full throughput: one push and one pop per cycle sustained, no bubbles.

## Test plan
- Reset then FIFO: capacity=4, word_size=8; back-push 0x11,0x22,0x33, front-pop ×3 → `data_out` 0x11,0x22,0x33 on consecutive cycles with `valid_out` high, then `empty`=1, count=0.
- LIFO: back-push 0xA1,0xA2,0xA3, back-pop ×3 → 0xA3,0xA2,0xA1.
- Front push + wrap: front-push 0x01 from reset (head wraps to 3), back-push 0x02, then 200 cycles of random push/pop checked against a reference deque model → no mismatch, count always matches model.
- Full/overflow: fill 4 words → `full`=1, `almost_full`=1 (af_level=2); 5th push alone → `overflow` pulse, contents unchanged; push+front-pop on full → both accepted, count stays 4.
- Empty/underflow: pop on empty → `underflow` pulse, `valid_out` 0; push 0x5A + pop same cycle on empty → `underflow`, count=1, next pop returns 0x5A.
- Reset mid-operation: with count=3, assert `rst` together with `wr` and `rd` → next cycle count=0, `empty`=1, `data_out`=0, `valid_out`=0.

Source files
------------

// File: rtl/circular_deque.sv
// Circular double-ended buffer: push/pop at either end, occupancy count, threshold flags,
// registered pop data with valid strobe and single-cycle overflow/underflow pulses.
module circular_deque #(
    parameter int word_size = 32,
    parameter int capacity  = 64,
    parameter int af_level  = capacity - 2,
    parameter int ae_level  = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr,
    input  logic                           wr_front,
    input  logic                           rd,
    input  logic                           rd_back,
    input  logic [word_size-1:0]           data_in,
    output logic [word_size-1:0]           data_out,
    output logic                           valid_out,
    output logic [$clog2(capacity+1)-1:0]  count,
    output logic                           full,
    output logic                           empty,
    output logic                           almost_full,
    output logic                           almost_empty,
    output logic                           overflow,
    output logic                           underflow
);
    localparam int IW = (capacity > 1) ? $clog2(capacity) : 1;
    localparam int CW = $clog2(capacity + 1);
    localparam logic [CW-1:0] CAP_C = CW'(capacity);
    localparam logic [CW-1:0] AF_C  = CW'(af_level);
    localparam logic [CW-1:0] AE_C  = CW'(ae_level);
    localparam logic [IW-1:0] LAST  = IW'(capacity - 1);

    logic [word_size-1:0] mem [capacity];

    logic [IW-1:0]        head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]        count_q, count_d;
    logic [word_size-1:0] data_out_q;
    logic                 valid_out_q, overflow_q, underflow_q;

    logic [IW-1:0] head_pop, tail_pop, pop_idx, push_idx;
    logic          pop_ok, push_ok;

    // Wrap by explicit compare so non-power-of-two capacities work.
    function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
        return (p == LAST) ? '0 : p + IW'(1);
    endfunction

    function automatic logic [IW-1:0] ptr_dec(input logic [IW-1:0] p);
        return (p == '0) ? LAST : p - IW'(1);
    endfunction

    // The pop sees pre-cycle state; the push is then applied to the post-pop pointers.
    always_comb begin
        pop_ok   = rd && (count_q != '0);
        pop_idx  = rd_back ? ptr_dec(tail_q) : head_q;
        head_pop = (pop_ok && !rd_back) ? ptr_inc(head_q) : head_q;
        tail_pop = (pop_ok && rd_back)  ? ptr_dec(tail_q) : tail_q;
        push_ok  = wr && ((count_q < CAP_C) || pop_ok);
        push_idx = wr_front ? ptr_dec(head_pop) : tail_pop;
        head_d   = (push_ok && wr_front)  ? ptr_dec(head_pop) : head_pop;
        tail_d   = (push_ok && !wr_front) ? ptr_inc(tail_pop) : tail_pop;
        count_d  = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CW'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            valid_out_q <= pop_ok;
            overflow_q  <= wr && !push_ok;
            underflow_q <= rd && !pop_ok;
            if (pop_ok) begin
                data_out_q <= mem[pop_idx];
            end
        end
    end

    // Storage is never cleared; a same-slot push and pop reads the old word.
    always_ff @(posedge clk) begin
        if (push_ok && !rst) begin
            mem[push_idx] <= data_in;
        end
    end

    assign data_out     = data_out_q;
    assign valid_out    = valid_out_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign count        = count_q;
    assign full         = (count_q == CAP_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);

endmodule

// File: tb/tb_circular_deque.sv
// Directed plus random bench for circular_deque, checked against a reference deque
// and a scoreboard of expected pop data.
module tb_circular_deque;
    localparam int W   = 8;
    localparam int CAP = 4;
    localparam int AF  = CAP - 2;
    localparam int AE  = 2;

    logic         clk = 1'b0;
    logic         rst, wr, wr_front, rd, rd_back;
    logic [W-1:0] data_in, data_out;
    logic         valid_out, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [2:0]   count;

    always #5 clk = ~clk;

    circular_deque #(
        .word_size(W), .capacity(CAP), .af_level(AF), .ae_level(AE)
    ) dut (
        .clk(clk), .rst(rst), .wr(wr), .wr_front(wr_front), .rd(rd), .rd_back(rd_back),
        .data_in(data_in), .data_out(data_out), .valid_out(valid_out), .count(count),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow)
    );

    int           checks   = 0;
    int           failures = 0;
    logic [W-1:0] model [$];
    logic [W-1:0] sb [$];
    logic [W-1:0] exp_dout = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, update the model, then check every output after the edge.
    task automatic step(input logic r, input logic w, input logic wf, input logic rq,
                        input logic rb, input logic [W-1:0] din);
        bit pop_ok, push_ok, exp_ovf, exp_udf;
        int sz;
        rst = r; wr = w; wr_front = wf; rd = rq; rd_back = rb; data_in = din;
        sz      = model.size();
        pop_ok  = !r && rq && (sz > 0);
        push_ok = !r && w && ((sz < CAP) || pop_ok);
        exp_ovf = !r && w && !push_ok;
        exp_udf = !r && rq && !pop_ok;
        if (r) begin
            model.delete();
            sb.delete();
            exp_dout = '0;
        end else begin
            if (pop_ok) begin
                if (rb) sb.push_back(model.pop_back());
                else    sb.push_back(model.pop_front());
            end
            if (push_ok) begin
                if (wf) model.push_front(din);
                else    model.push_back(din);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0; wr = 1'b0; rd = 1'b0;
        if (pop_ok) exp_dout = sb.pop_front();
        sz = model.size();
        check("valid_out", 32'(valid_out), 32'(pop_ok));
        check("data_out", 32'(data_out), 32'(exp_dout));
        check("count", 32'(count), sz);
        check("full", 32'(full), 32'(sz == CAP));
        check("empty", 32'(empty), 32'(sz == 0));
        check("almost_full", 32'(almost_full), 32'(sz >= AF));
        check("almost_empty", 32'(almost_empty), 32'(sz <= AE));
        check("overflow", 32'(overflow), 32'(exp_ovf));
        check("underflow", 32'(underflow), 32'(exp_udf));
        $display("t=%0t rst=%0b wr=%0b wf=%0b rd=%0b rb=%0b din=%02h -> dout=%02h vld=%0b cnt=%0d ovf=%0b udf=%0b",
                 $time, r, w, wf, rq, rb, din, data_out, valid_out, count, overflow, underflow);
    endtask

    initial begin
        rst = 1'b1; wr = 1'b0; wr_front = 1'b0; rd = 1'b0; rd_back = 1'b0; data_in = '0;

        // Reset, then FIFO order.
        step(1, 0, 0, 0, 0, 8'h00);
        step(1, 0, 0, 0, 0, 8'h00);
        step(0, 1, 0, 0, 0, 8'h11);
        step(0, 1, 0, 0, 0, 8'h22);
        step(0, 1, 0, 0, 0, 8'h33);
        repeat (3) step(0, 0, 0, 1, 0, 8'h00);
        step(0, 0, 0, 0, 0, 8'h00);

        // LIFO order.
        step(0, 1, 0, 0, 0, 8'hA1);
        step(0, 1, 0, 0, 0, 8'hA2);
        step(0, 1, 0, 0, 0, 8'hA3);
        repeat (3) step(0, 0, 0, 1, 1, 8'h00);

        // Front push wraps head from reset, then random traffic.
        step(1, 0, 0, 0, 0, 8'h00);
        step(0, 1, 1, 0, 0, 8'h01);
        step(0, 1, 0, 0, 0, 8'h02);
        for (int i = 0; i < 200; i++) begin
            step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
        end

        // Full and overflow.
        step(1, 0, 0, 0, 0, 8'h00);
        step(0, 1, 0, 0, 0, 8'hC1);
        step(0, 1, 0, 0, 0, 8'hC2);
        step(0, 1, 0, 0, 0, 8'hC3);
        step(0, 1, 0, 0, 0, 8'hC4);
        step(0, 1, 0, 0, 0, 8'hC5);
        step(0, 1, 0, 1, 0, 8'hC6);
        step(0, 1, 1, 1, 1, 8'hC7);
        repeat (5) step(0, 0, 0, 1, 0, 8'h00);

        // Empty and underflow, push+pop on empty.
        step(0, 0, 0, 1, 0, 8'h00);
        step(0, 1, 0, 1, 0, 8'h5A);
        step(0, 0, 0, 1, 0, 8'h00);

        // Reset mid-operation overrides push and pop.
        step(0, 1, 0, 0, 0, 8'h71);
        step(0, 1, 0, 0, 0, 8'h72);
        step(0, 1, 0, 0, 0, 8'h73);
        step(1, 1, 0, 1, 0, 8'h74);
        step(0, 0, 0, 0, 0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
